// File: rtl/led_ctrl_pkg.sv
// Shared state encoding and sizing helper for the LED shift sequencer.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TURN = 2'd2
  } led_state_e;

  // Bits needed to hold 0..steps inclusive.
  function automatic int cnt_w(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running step prescaler: counts while enabled and flags the cycle it wraps.
module led_tick_prescaler #(
  parameter int DELAY_SIZE = 9
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  logic [DELAY_SIZE-1:0] count;

  // The period is a power of two, so the natural rollover is the wrap.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + DELAY_SIZE'(1);
    end
  end

  assign wrap = en && (&count);

endmodule

// File: rtl/led_shift_sequencer.sv
// Run/stop/direction controller issuing step pulses and a reverse level to the LED shifter.
// Optional build macro LED_AUTO_BOUNCE_EN enables the automatic direction flip.
//
// state | meaning
// IDLE  | halted, prescaler cleared, rev_req flips direction directly
// RUN   | prescaler counting, one step pulse per wrap
// TURN  | single cycle, flips direction and restarts the step period
module led_shift_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int   DELAY_SIZE   = 9,
  parameter int   WIDTH        = 5,
  parameter int   BOUNCE_STEPS = 25,
  localparam int  CNT_W        = cnt_w(BOUNCE_STEPS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             rev_req,
  output logic             step,
  output logic             reverse,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt
);

  if (BOUNCE_STEPS < 1 || WIDTH < 1 || DELAY_SIZE < 1) begin : g_param_check
    $error("led_shift_sequencer: BOUNCE_STEPS, WIDTH and DELAY_SIZE must all be >= 1");
  end

  led_state_e       state_q, state_d;
  logic             presc_clr, presc_en, presc_wrap, auto_turn;
  logic             step_d, reverse_d;
  logic [CNT_W-1:0] cnt_d;

  led_tick_prescaler #(.DELAY_SIZE(DELAY_SIZE)) u_presc (
    .clk  (clk),
    .rstn (rstn),
    .clr  (presc_clr),
    .en   (presc_en),
    .wrap (presc_wrap)
  );

`ifdef LED_AUTO_BOUNCE_EN
  // Turn on the step that brings the count since the last turn to BOUNCE_STEPS.
  assign auto_turn = presc_wrap && ((int'(step_cnt) + 1) >= BOUNCE_STEPS);
`else
  assign auto_turn = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = 1'b0;
    reverse_d = reverse;
    cnt_d     = step_cnt;
    case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          if (rev_req) begin
            reverse_d = ~reverse;
          end else if (start) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          if (presc_wrap) begin
            step_d = 1'b1;
            if (int'(step_cnt) < BOUNCE_STEPS) begin
              cnt_d = step_cnt + CNT_W'(1);
            end
          end
          if (rev_req || auto_turn) begin
            state_d = ST_TURN;
          end
        end
      end
      ST_TURN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          reverse_d = ~reverse;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counting only continues while staying in RUN; every other transition restarts the period.
  assign presc_en  = (state_q == ST_RUN);
  assign presc_clr = (state_q != ST_RUN) || (state_d != ST_RUN);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      step     <= 1'b0;
      reverse  <= 1'b0;
      busy     <= 1'b0;
      step_cnt <= '0;
    end else begin
      state_q  <= state_d;
      step     <= step_d;
      reverse  <= reverse_d;
      busy     <= (state_d != ST_IDLE);
      step_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Scoreboard bench for led_shift_sequencer with a cycle-level behavioural model.
module tb_led_shift_sequencer;

  localparam int DS     = 4;
  localparam int NCYCLE = 16;
  localparam int B      = 3;
`ifdef LED_AUTO_BOUNCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       rev_req = 1'b0;
  logic       step;
  logic       reverse;
  logic       busy;
  logic [1:0] step_cnt;

  led_shift_sequencer #(.DELAY_SIZE(DS), .WIDTH(5), .BOUNCE_STEPS(B)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .rev_req  (rev_req),
    .step     (step),
    .reverse  (reverse),
    .busy     (busy),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       step;
    logic       reverse;
    logic       busy;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;

  // Model: mode 0 = halted, 1 = stepping, 2 = turning; elapsed counts clocks since the period began.
  int   m_mode = 0;
  int   m_el = 0;
  int   m_cnt = 0;
  bit   m_rev = 1'b0;
  bit   m_step = 1'b0;

  task automatic model(input bit r, input bit s, input bit p, input bit v);
    exp_t e;
    bit   tick;
    m_step = 1'b0;
    if (!r) begin
      m_mode = 0; m_el = 0; m_cnt = 0; m_rev = 1'b0;
    end else begin
      case (m_mode)
        0: if (!p) begin
          if (v) m_rev = !m_rev;
          else if (s) begin m_mode = 1; m_el = 0; end
        end
        1: if (p) begin
          m_mode = 0; m_el = 0;
        end else begin
          m_el++;
          tick = (m_el % NCYCLE) == 0;
          if (tick) begin
            m_step = 1'b1;
            if (m_cnt < B) m_cnt++;
          end
          if (v || (AUTO && tick && m_cnt >= B)) m_mode = 2;
        end
        default: if (p) begin
          m_mode = 0; m_el = 0;
        end else begin
          m_rev = !m_rev; m_cnt = 0; m_mode = 1; m_el = 0;
        end
      endcase
    end
    e.step    = m_step;
    e.reverse = m_rev;
    e.busy    = (m_mode != 0);
    e.cnt     = 2'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic drive(input bit r, input bit s, input bit p, input bit v);
    rstn = r; start = s; stop = p; rev_req = v;
    @(posedge clk);
    model(r, s, p, v);
    #1;
    rstn = 1'b1; start = 1'b0; stop = 1'b0; rev_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if ({step, reverse, busy, step_cnt} !== {e.step, e.reverse, e.busy, e.cnt}) begin
        failed++;
        $display("FAIL outputs t=%0t got step=%0b reverse=%0b busy=%0b step_cnt=%0d, expected step=%0b reverse=%0b busy=%0b step_cnt=%0d",
                 $time, step, reverse, busy, step_cnt, e.step, e.reverse, e.busy, e.cnt);
      end
    end
  end

  initial begin
    #2;
    // Reset held with start asserted.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    // Run through three steps and the bounce region.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(80);
    // rev_req and stop together mid-period.
    idle(5);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);
    // rev_req while halted.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Fresh run, then rev_req on the edge completing the third step since the last turn.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (m_mode == 1 && (m_el % NCYCLE) == NCYCLE - 1 && m_cnt == B - 1) break;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    idle(40);
    // stop on a wrapping edge suppresses the step.
    for (int i = 0; i < 40; i++) begin
      if (m_mode == 1 && (m_el % NCYCLE) == NCYCLE - 1) break;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    // Reset at the last prescaler count of a period.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (m_mode == 1 && (m_el % NCYCLE) == NCYCLE - 1) break;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Randomised pulses.
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(0, 399) != 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 79) == 0,
            $urandom_range(0, 29) == 0);
    end
    idle(2);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
